// File: rtl/mips_pipe_pkg.sv
// Shared pipeline types and constants for the 5-stage MIPS core.
// Used by hazard_controller and hazard_detect.
package mips_pipe_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } hz_state_t;

  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms for the instruction sitting in decode.
// Branches resolve in ID, so they also wait on EX results and in-flight loads.
module hazard_detect
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [5:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic                  uses_rt,
  input  logic                  idex_mem_read,
  input  logic                  idex_reg_write,
  input  logic [REG_ADDR_W-1:0] idex_dst,
  input  logic                  exmem_mem_read,
  input  logic [REG_ADDR_W-1:0] exmem_dst,
  output logic                  is_branch,
  output logic                  load_use,
  output logic                  br_stall
);

  localparam logic [REG_ADDR_W-1:0] ZERO =
    REG_ADDR_W'(REG_ZERO);

  logic idex_match;
  logic exmem_match;

  function automatic logic src_match(
    input logic [REG_ADDR_W-1:0] dst,
    input logic [REG_ADDR_W-1:0] a,
    input logic [REG_ADDR_W-1:0] b,
    input logic                  b_en
  );
    // $zero is never a real producer
    return (dst != ZERO) &&
           ((dst == a) || (b_en && (dst == b)));
  endfunction

  always_comb begin
    is_branch   = (opcode == OP_BEQ) ||
                  (opcode == OP_BNE);
    idex_match  = src_match(idex_dst, rs, rt, uses_rt);
    exmem_match = src_match(exmem_dst, rs, rt, uses_rt);
    load_use    = idex_mem_read && idex_match;
    br_stall    = is_branch &&
                  ((idex_reg_write && idex_match) ||
                   (exmem_mem_read && exmem_match));
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: stalls, branch flush and memory freeze with timeout.
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module hazard_controller
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            ifid_opcode,
  input  logic [REG_ADDR_W-1:0] ifid_rs,
  input  logic [REG_ADDR_W-1:0] ifid_rt,
  input  logic                  ifid_uses_rt,
  input  logic                  idex_mem_read,
  input  logic                  idex_reg_write,
  input  logic [REG_ADDR_W-1:0] idex_dst,
  input  logic                  exmem_mem_read,
  input  logic [REG_ADDR_W-1:0] exmem_dst,
  input  logic                  mem_access,
  input  logic                  mem_ready,
  input  logic                  branch_taken,
  output logic                  pc_write_en,
  output logic                  ifid_write_en,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  pipe_freeze,
  output logic                  pc_src_branch,
  output logic                  mem_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      flush_count,
  output logic [CNT_W-1:0]      freeze_cycles
`endif
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);

  hz_state_t     state;
  hz_state_t     state_nxt;
  logic [TW-1:0] freeze_cnt;
  logic          is_branch;
  logic          load_use;
  logic          br_stall;
  logic          mem_wait;
  logic          do_stall;
  logic          do_flush;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_detect (
    .opcode        (ifid_opcode),
    .rs            (ifid_rs),
    .rt            (ifid_rt),
    .uses_rt       (ifid_uses_rt),
    .idex_mem_read (idex_mem_read),
    .idex_reg_write(idex_reg_write),
    .idex_dst      (idex_dst),
    .exmem_mem_read(exmem_mem_read),
    .exmem_dst     (exmem_dst),
    .is_branch     (is_branch),
    .load_use      (load_use),
    .br_stall      (br_stall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pc_write_en   = 1'b1;
    ifid_write_en = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;
    pipe_freeze   = 1'b0;
    pc_src_branch = 1'b0;
    do_stall      = 1'b0;
    do_flush      = 1'b0;
    // in FREEZE only mem_ready matters; release evaluates as RUN
    mem_wait = (state == FREEZE) ? !mem_ready
                                 : (mem_access && !mem_ready);
    if (rst) begin
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
      ifid_flush    = 1'b1;
      idex_bubble   = 1'b1;
    end else if (mem_wait) begin
      state_nxt     = FREEZE;
      pipe_freeze   = 1'b1;
      pc_write_en   = 1'b0;
      ifid_write_en = 1'b0;
    end else begin
      state_nxt = RUN;
      if (load_use || br_stall) begin
        do_stall      = 1'b1;
        pc_write_en   = 1'b0;
        ifid_write_en = 1'b0;
        idex_bubble   = 1'b1;
      end else if (branch_taken && is_branch) begin
        do_flush      = 1'b1;
        pc_src_branch = 1'b1;
        ifid_flush    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze_cnt  <= '0;
      mem_timeout <= 1'b0;
    end else if (pipe_freeze) begin
      if (freeze_cnt != TMAX)
        freeze_cnt <= freeze_cnt + 1'b1;
      if (freeze_cnt >= TMAX - 1'b1)
        mem_timeout <= 1'b1;
    end else begin
      freeze_cnt <= '0;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles  <= '0;
      flush_count   <= '0;
      freeze_cycles <= '0;
    end else begin
      if (do_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (do_flush && flush_count != '1)
        flush_count <= flush_count + 1'b1;
      if (pipe_freeze && freeze_cycles != '1)
        freeze_cycles <= freeze_cycles + 1'b1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf = ^{do_stall, do_flush, CNT_W[0]};
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MEM_TIMEOUT=4).
// Perf counters are checked when HAZ_PERF_CNT_EN is defined.
module tb_hazard_controller;
  import mips_pipe_pkg::*;

  localparam int CW = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] ifid_opcode;
  logic [4:0] ifid_rs, ifid_rt, idex_dst, exmem_dst;
  logic       ifid_uses_rt, idex_mem_read, idex_reg_write;
  logic       exmem_mem_read, mem_access, mem_ready;
  logic       branch_taken;
  logic       pc_write_en, ifid_write_en, ifid_flush;
  logic       idex_bubble, pipe_freeze, pc_src_branch;
  logic       mem_timeout;
  logic [6:0] o;
`ifdef HAZ_PERF_CNT_EN
  logic [CW-1:0] stall_cycles, flush_count, freeze_cycles;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // {pcw, ifw, flush, bubble, freeze, pcsrc, timeout}
  localparam logic [6:0] V_RUN  = 7'b1100000;
  localparam logic [6:0] V_STL  = 7'b0001000;
  localparam logic [6:0] V_FLS  = 7'b1110010;
  localparam logic [6:0] V_FRZ  = 7'b0000100;
  localparam logic [6:0] V_RST  = 7'b0011000;
  localparam logic [6:0] V_FRZT = 7'b0000101;
  localparam logic [6:0] V_RUNT = 7'b1100001;

  always #5 clk = ~clk;

  hazard_controller #(
    .REG_ADDR_W (5),
    .MEM_TIMEOUT(4),
    .CNT_W      (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifid_opcode   (ifid_opcode),
    .ifid_rs       (ifid_rs),
    .ifid_rt       (ifid_rt),
    .ifid_uses_rt  (ifid_uses_rt),
    .idex_mem_read (idex_mem_read),
    .idex_reg_write(idex_reg_write),
    .idex_dst      (idex_dst),
    .exmem_mem_read(exmem_mem_read),
    .exmem_dst     (exmem_dst),
    .mem_access    (mem_access),
    .mem_ready     (mem_ready),
    .branch_taken  (branch_taken),
    .pc_write_en   (pc_write_en),
    .ifid_write_en (ifid_write_en),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .pipe_freeze   (pipe_freeze),
    .pc_src_branch (pc_src_branch),
    .mem_timeout   (mem_timeout)
`ifdef HAZ_PERF_CNT_EN
    ,
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count),
    .freeze_cycles (freeze_cycles)
`endif
  );

  assign o = {pc_write_en, ifid_write_en, ifid_flush,
              idex_bubble, pipe_freeze, pc_src_branch,
              mem_timeout};

  task automatic chk(input string tag,
                     input logic [6:0] exp);
    n_cmp++;
    assert (o === exp) else begin
      n_err++;
      $error("FAIL %s got=%b exp=%b", tag, o, exp);
    end
  endtask

  task automatic chk32(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    ifid_opcode    = 6'h00;
    ifid_rs        = 5'd0;
    ifid_rt        = 5'd0;
    ifid_uses_rt   = 1'b0;
    idex_mem_read  = 1'b0;
    idex_reg_write = 1'b0;
    idex_dst       = 5'd0;
    exmem_mem_read = 1'b0;
    exmem_dst      = 5'd0;
    mem_access     = 1'b0;
    mem_ready      = 1'b1;
    branch_taken   = 1'b0;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_use_add();
    idle();
    idex_mem_read  = 1'b1;
    idex_reg_write = 1'b1;
    idex_dst       = 5'd2;
    ifid_rs        = 5'd2;
    ifid_rt        = 5'd4;
    ifid_uses_rt   = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    load_use_add();
    branch_taken = 1'b1;
    #2;
    chk("reset_outputs", V_RST);
    nxt(); nxt();
    rst = 1'b0;
    idle();
    settle();
    chk("idle_run", V_RUN);

    // lw $2 ; add $3,$2,$4
    nxt(); load_use_add(); settle();
    chk("load_use_stall", V_STL);
    nxt(); idle(); ifid_rs = 5'd2; ifid_rt = 5'd4;
    ifid_uses_rt = 1'b1; settle();
    chk("load_use_resume", V_RUN);

    // lw $5 ; beq $5,$0 (stale taken must be ignored)
    nxt(); idle();
    idex_mem_read = 1'b1; idex_reg_write = 1'b1;
    idex_dst = 5'd5; ifid_opcode = OP_BEQ;
    ifid_rs = 5'd5; ifid_uses_rt = 1'b1;
    branch_taken = 1'b1; settle();
    chk("lw_beq_stall1", V_STL);
    nxt(); idle();
    exmem_mem_read = 1'b1; exmem_dst = 5'd5;
    ifid_opcode = OP_BEQ; ifid_rs = 5'd5;
    ifid_uses_rt = 1'b1; branch_taken = 1'b1; settle();
    chk("lw_beq_stall2", V_STL);
    nxt(); idle();
    ifid_opcode = OP_BEQ; ifid_rs = 5'd5;
    ifid_uses_rt = 1'b1; branch_taken = 1'b1; settle();
    chk("beq_taken_flush", V_FLS);
    nxt(); idle(); settle();
    chk("after_flush", V_RUN);

    // memory not ready for 3 cycles
    nxt(); idle(); mem_access = 1'b1; mem_ready = 1'b0;
    settle();
    chk("freeze_c1", V_FRZ);
    nxt(); settle();
    chk("freeze_c2", V_FRZ);
    nxt(); settle();
    chk("freeze_c3", V_FRZ);
    nxt(); mem_ready = 1'b1; settle();
    chk("freeze_release", V_RUN);
    nxt(); idle(); settle();
    chk("post_release", V_RUN);

`ifdef HAZ_PERF_CNT_EN
    chk32("perf_stalls", stall_cycles, 32'd3);
    chk32("perf_flushes", flush_count, 32'd1);
    chk32("perf_freezes", freeze_cycles, 32'd3);
`endif

    // rt-side match, gated by uses_rt
    nxt(); idle(); idex_mem_read = 1'b1;
    idex_dst = 5'd7; ifid_rs = 5'd1; ifid_rt = 5'd7;
    ifid_uses_rt = 1'b1; settle();
    chk("rt_load_use", V_STL);
    nxt(); ifid_uses_rt = 1'b0; settle();
    chk("rt_not_used", V_RUN);

    // $zero never stalls
    nxt(); idle(); idex_mem_read = 1'b1;
    idex_dst = 5'd0; ifid_rs = 5'd0; settle();
    chk("reg_zero", V_RUN);

    // bne waiting on an ALU result in EX
    nxt(); idle(); idex_reg_write = 1'b1;
    idex_dst = 5'd9; ifid_opcode = OP_BNE;
    ifid_rs = 5'd3; ifid_rt = 5'd9;
    ifid_uses_rt = 1'b1; settle();
    chk("bne_alu_stall", V_STL);
    nxt(); idle(); ifid_opcode = OP_BNE;
    ifid_rs = 5'd3; ifid_rt = 5'd9;
    ifid_uses_rt = 1'b1; settle();
    chk("bne_not_taken", V_RUN);

    // ALU result in EX does not stall a non-branch
    nxt(); idle(); idex_reg_write = 1'b1;
    idex_dst = 5'd3; ifid_rs = 5'd3; settle();
    chk("alu_fwd_no_stall", V_RUN);

    // taken flag on a non-branch opcode
    nxt(); idle(); ifid_opcode = 6'h23;
    branch_taken = 1'b1; settle();
    chk("non_branch_taken", V_RUN);

    // freeze outranks a pending load-use; release honours it
    nxt(); load_use_add(); mem_access = 1'b1;
    mem_ready = 1'b0; settle();
    chk("freeze_over_stall", V_FRZ);
    nxt(); mem_ready = 1'b1; settle();
    chk("release_stall", V_STL);

    // timeout after 4 freeze cycles, sticky
    nxt(); idle(); mem_access = 1'b1; mem_ready = 1'b0;
    settle();
    chk("tmo_c1", V_FRZ);
    nxt(); settle();
    nxt(); settle();
    nxt(); settle();
    chk("tmo_c4", V_FRZ);
    nxt(); settle();
    chk("tmo_set", V_FRZT);
    nxt(); settle();
    chk("tmo_hold_frz", V_FRZT);
    nxt(); mem_ready = 1'b1; settle();
    chk("tmo_sticky_run", V_RUNT);

    // reset in the middle of a freeze
    nxt(); mem_ready = 1'b0; settle();
    chk("refreeze", V_FRZT);
    nxt(); rst = 1'b1; settle();
    chk("rst_mid_freeze", V_RST);
    nxt(); rst = 1'b0; mem_ready = 1'b1; settle();
    chk("rst_back_run", V_RUN);
    nxt(); mem_ready = 1'b0; settle();
    nxt(); settle();
    nxt(); settle();
    nxt(); settle();
    chk("cnt_zeroed", V_FRZ);
    nxt(); idle(); settle();
    chk("final_release", V_RUNT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
